atm_bank_responder: RTL and testbench

Account-side responder for the ATM controller. Accepts one transaction request at a time: PIN verify, withdraw, balance query or logout. Evaluates the request against the stored PIN, the attempt counter and the account balance, then returns a coded response over a valid/ready handshake. Sits between the ATM front-end FSM and the cash-dispense path. Holds session, lockout and balance state.

---
 rtl/atm_pkg.sv | 26 ++
 rtl/atm_pin_guard.sv | 48 ++++
 rtl/atm_bank_responder.sv | 181 ++++++++++++++++++
 tb/tb_atm_bank_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types for the ATM bank responder: request ops, response codes and FSM states.
package atm_pkg;

  typedef enum logic [1:0] {
    OP_VERIFY   = 2'd0,
    OP_WITHDRAW = 2'd1,
    OP_BALANCE  = 2'd2,
    OP_LOGOUT   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    RSP_OK      = 3'd0,
    RSP_BAD_PIN = 3'd1,
    RSP_LOCKED  = 3'd2,
    RSP_NO_AUTH = 3'd3,
    RSP_INSUFF  = 3'd4,
    RSP_BAD_AMT = 3'd5
  } rsp_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/atm_pin_guard.sv
// Wrong-PIN attempt counter and lockout latch. Only reset clears the lock.
module atm_pin_guard #(
  parameter int unsigned MAX_TRIES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic check_i,
  input  logic match_i,
  output logic locked_o,
  output logic fail_is_lock_o
);

  localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);

  logic [TriesW-1:0] tries_q, tries_d, tries_inc;
  logic              locked_q, locked_d;

  assign tries_inc      = tries_q + TriesW'(1);
  // High when one more wrong PIN would exhaust the allowance.
  assign fail_is_lock_o = (tries_inc == TriesW'(MAX_TRIES));
  assign locked_o       = locked_q;

  always_comb begin
    tries_d  = tries_q;
    locked_d = locked_q;
    if (check_i && !locked_q) begin
      if (match_i) begin
        tries_d = '0;
      end else begin
        tries_d = tries_inc;
        if (fail_is_lock_o) begin
          locked_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tries_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      tries_q  <= tries_d;
      locked_q <= locked_d;
    end
  end

endmodule

// File: rtl/atm_bank_responder.sv
// Account-side responder: accepts one request, evaluates it after a fixed lookup latency,
// commits session/lock/balance state and holds a coded response until it is taken.
module atm_bank_responder
  import atm_pkg::*;
#(
  parameter int unsigned       PIN_W        = 16,
  parameter logic [PIN_W-1:0]  PIN_VALUE    = 16'h1234,
  parameter int unsigned       AMT_W        = 8,
  parameter int unsigned       BAL_W        = 16,
  parameter int unsigned       INIT_BALANCE = 500,
  parameter int unsigned       MAX_TRIES    = 3,
  parameter int unsigned       BUSY_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [PIN_W-1:0] req_pin,
  input  logic [AMT_W-1:0] req_amount,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_code,
  output logic [BAL_W-1:0] rsp_balance,
  output logic             session_active,
  output logic             locked
);

  localparam int unsigned CntW = $clog2(BUSY_CYCLES + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [PIN_W-1:0]  pin_q, pin_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic [BAL_W-1:0]  bal_q, bal_d;
  logic              sess_q, sess_d;
  rsp_code_e         code_q, code_d;
  logic [BAL_W-1:0]  rsp_bal_q, rsp_bal_d;

  logic              commit;
  logic              pin_match;
  logic              pin_check;
  logic              locked_w;
  logic              fail_is_lock;
  logic [BAL_W-1:0]  amt_ext;
  rsp_code_e         eval_code;
  logic              eval_sess;
  logic [BAL_W-1:0]  eval_bal;

  assign commit    = (state_q == ST_EXEC) && (cnt_q == '0);
  assign pin_match = (pin_q == PIN_VALUE);
  assign pin_check = commit && (op_q == OP_VERIFY);
  assign amt_ext   = BAL_W'(amt_q);

  atm_pin_guard #(
    .MAX_TRIES (MAX_TRIES)
  ) u_pin_guard (
    .clk            (clk),
    .reset_n        (reset_n),
    .check_i        (pin_check),
    .match_i        (pin_match),
    .locked_o       (locked_w),
    .fail_is_lock_o (fail_is_lock)
  );

  // Outcome of the captured request against current state; only applied on commit.
  always_comb begin
    eval_code = RSP_OK;
    eval_sess = sess_q;
    eval_bal  = bal_q;
    unique case (op_q)
      OP_VERIFY: begin
        if (locked_w) begin
          eval_code = RSP_LOCKED;
        end else if (pin_match) begin
          eval_sess = 1'b1;
        end else begin
          eval_sess = 1'b0;
          eval_code = fail_is_lock ? RSP_LOCKED : RSP_BAD_PIN;
        end
      end
      OP_WITHDRAW: begin
        if (!sess_q) begin
          eval_code = RSP_NO_AUTH;
        end else if (amt_q == '0) begin
          eval_code = RSP_BAD_AMT;
        end else if (amt_ext > bal_q) begin
          eval_code = RSP_INSUFF;
        end else begin
          eval_bal = bal_q - amt_ext;
        end
      end
      OP_BALANCE: begin
        if (!sess_q) begin
          eval_code = RSP_NO_AUTH;
        end
      end
      OP_LOGOUT: begin
        eval_sess = 1'b0;
      end
      default: begin
        eval_code = RSP_OK;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    pin_d     = pin_q;
    amt_d     = amt_q;
    bal_d     = bal_q;
    sess_d    = sess_q;
    code_d    = code_q;
    rsp_bal_d = rsp_bal_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = op_e'(req_op);
          pin_d   = req_pin;
          amt_d   = req_amount;
          cnt_d   = CntW'(BUSY_CYCLES);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (commit) begin
          bal_d     = eval_bal;
          sess_d    = eval_sess;
          code_d    = eval_code;
          rsp_bal_d = eval_sess ? eval_bal : '0;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_VERIFY;
      pin_q     <= '0;
      amt_q     <= '0;
      bal_q     <= BAL_W'(INIT_BALANCE);
      sess_q    <= 1'b0;
      code_q    <= RSP_OK;
      rsp_bal_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      pin_q     <= pin_d;
      amt_q     <= amt_d;
      bal_q     <= bal_d;
      sess_q    <= sess_d;
      code_q    <= code_d;
      rsp_bal_q <= rsp_bal_d;
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign rsp_valid      = (state_q == ST_RESP);
  assign rsp_code       = code_q;
  assign rsp_balance    = rsp_bal_q;
  assign session_active = sess_q;
  assign locked         = locked_w;

endmodule

// File: tb/tb_atm_bank_responder.sv
// Directed plus randomized bench for atm_bank_responder against an account-level reference model.
module tb_atm_bank_responder;

  localparam int unsigned PIN_W        = 16;
  localparam logic [15:0] PIN_VALUE    = 16'h1234;
  localparam int unsigned AMT_W        = 8;
  localparam int unsigned BAL_W        = 16;
  localparam int unsigned INIT_BALANCE = 500;
  localparam int unsigned MAX_TRIES    = 3;
  localparam int unsigned BUSY_CYCLES  = 2;

  localparam int OpVerify = 0, OpWithdraw = 1, OpBalance = 2, OpLogout = 3;
  localparam int COk = 0, CBadPin = 1, CLocked = 2, CNoAuth = 3, CInsuff = 4, CBadAmt = 5;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = '0;
  logic [PIN_W-1:0] req_pin = '0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [2:0]       rsp_code;
  logic [BAL_W-1:0] rsp_balance;
  logic             session_active;
  logic             locked;

  atm_bank_responder #(
    .PIN_W        (PIN_W),
    .PIN_VALUE    (PIN_VALUE),
    .AMT_W        (AMT_W),
    .BAL_W        (BAL_W),
    .INIT_BALANCE (INIT_BALANCE),
    .MAX_TRIES    (MAX_TRIES),
    .BUSY_CYCLES  (BUSY_CYCLES)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_pin        (req_pin),
    .req_amount     (req_amount),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_code       (rsp_code),
    .rsp_balance    (rsp_balance),
    .session_active (session_active),
    .locked         (locked)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Account model
  int m_bal;
  int m_tries;
  bit m_sess;
  bit m_locked;
  int exp_code;
  int exp_bal;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bal    = INIT_BALANCE;
    m_tries  = 0;
    m_sess   = 1'b0;
    m_locked = 1'b0;
  endtask

  task automatic model_step(input int op, input int pin, input int amt);
    case (op)
      OpVerify: begin
        if (m_locked) begin
          exp_code = CLocked;
        end else if (pin == int'(PIN_VALUE)) begin
          exp_code = COk;
          m_sess   = 1'b1;
          m_tries  = 0;
        end else begin
          m_tries++;
          m_sess = 1'b0;
          if (m_tries >= int'(MAX_TRIES)) begin
            m_locked = 1'b1;
            exp_code = CLocked;
          end else begin
            exp_code = CBadPin;
          end
        end
      end
      OpWithdraw: begin
        if (!m_sess)          exp_code = CNoAuth;
        else if (amt == 0)    exp_code = CBadAmt;
        else if (amt > m_bal) exp_code = CInsuff;
        else begin
          m_bal    = m_bal - amt;
          exp_code = COk;
        end
      end
      OpBalance: exp_code = m_sess ? COk : CNoAuth;
      default: begin
        m_sess   = 1'b0;
        exp_code = COk;
      end
    endcase
    exp_bal = m_sess ? m_bal : 0;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    rsp_ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Presents a request and holds it through the accept edge; called at posedge+1.
  task automatic send(input int op, input int pin, input int amt);
    int n = 0;
    req_op     = op[1:0];
    req_pin    = pin[15:0];
    req_amount = amt[7:0];
    req_valid  = 1'b1;
    while (!req_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    model_step(op, pin, amt);
  endtask

  // Waits for the response, checks it, optionally stalls, then consumes it.
  task automatic recv(input int stall);
    int lat = 0;
    logic [2:0]       code_s;
    logic [BAL_W-1:0] bal_s;
    chk("exec_not_ready", {31'd0, req_ready}, 32'd0);
    while (!rsp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, BUSY_CYCLES + 1);
    chk("rsp_code", {29'd0, rsp_code}, exp_code);
    chk("rsp_balance", {16'd0, rsp_balance}, exp_bal);
    chk("session_active", {31'd0, session_active}, {31'd0, m_sess});
    chk("locked", {31'd0, locked}, {31'd0, m_locked});
    code_s = rsp_code;
    bal_s  = rsp_balance;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
      chk("stall_code", {29'd0, rsp_code}, {29'd0, code_s});
      chk("stall_bal", {16'd0, rsp_balance}, {16'd0, bal_s});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic txn(input int op, input int pin, input int amt);
    send(op, pin, amt);
    recv(0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_code", {29'd0, rsp_code}, 32'd0);
    chk("rst_rsp_balance", {16'd0, rsp_balance}, 32'd0);
    chk("rst_session", {31'd0, session_active}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);

    // Unauthenticated balance, then a normal session
    txn(OpBalance, 0, 0);
    chk("noauth_code", {29'd0, rsp_code}, CNoAuth);
    txn(OpVerify, 16'h1234, 0);
    txn(OpWithdraw, 0, 100);
    chk("bal_400", {16'd0, rsp_balance}, 32'd400);
    txn(OpWithdraw, 0, 0);
    txn(OpWithdraw, 0, 200);
    txn(OpWithdraw, 0, 255);
    chk("insuff_code", {29'd0, rsp_code}, CInsuff);
    txn(OpWithdraw, 0, 200);
    chk("bal_zero", {16'd0, rsp_balance}, 32'd0);
    txn(OpBalance, 0, 0);

    // Lockout
    txn(OpLogout, 0, 0);
    txn(OpVerify, 16'h1111, 0);
    txn(OpVerify, 16'h2222, 0);
    txn(OpVerify, 16'h3333, 0);
    chk("lock_code", {29'd0, rsp_code}, CLocked);
    txn(OpVerify, 16'h1234, 0);
    txn(OpBalance, 0, 0);
    txn(OpWithdraw, 0, 10);
    txn(OpLogout, 0, 0);

    // Backpressure with a second request waiting
    do_reset();
    send(OpVerify, 16'h1234, 0);
    req_op    = OpBalance[1:0];
    req_valid = 1'b1;
    recv(5);
    send(OpBalance, 0, 0);
    recv(0);

    // Reset during EXEC discards the withdraw
    txn(OpWithdraw, 0, 50);
    send(OpWithdraw, 0, 100);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_session", {31'd0, session_active}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    txn(OpBalance, 0, 0);
    txn(OpVerify, 16'h1234, 0);
    txn(OpBalance, 0, 0);
    chk("bal_restored", {16'd0, rsp_balance}, INIT_BALANCE);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 80; i++) begin
      int op, pin, amt;
      op  = int'($urandom_range(0, 3));
      pin = ($urandom_range(0, 3) != 0) ? int'(PIN_VALUE) : int'($urandom_range(0, 65535));
      amt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      send(op, pin, amt);
      recv(int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
